// File: rtl/store_write_buffer_pkg.sv
// store_write_buffer_pkg: shared widths, entry layout and fence states for the store write buffer
package store_write_buffer_pkg;
  localparam int WB_DEPTH = 4;
  localparam int WB_ADDR_WIDTH = 30;
  localparam int WB_DATA_WIDTH = 32;
  typedef struct packed {
    logic valid;
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;
  typedef enum logic [1:0] {WB_IDLE, WB_WAIT, WB_DONE} wb_fence_state_e;
endpackage

// File: rtl/store_write_buffer_fwd_match.sv
// wb_fwd_match: youngest-first address match over the live window head..tail-1
module wb_fwd_match
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int PW = $clog2(DEPTH) + 1
) (
  input  wb_entry_t              entries [DEPTH],
  input  logic [PW-1:0]          head,
  input  logic [PW-1:0]          tail,
  input  logic [WB_ADDR_WIDTH-1:0] addr,
  output logic                   hit,
  output logic [PW-2:0]          idx
);
  localparam int AW = PW - 1;
  logic [PW-1:0] cnt;
  logic [AW-1:0] i;
  assign cnt = tail - head;
  // scan oldest to youngest so the last match wins
  always_comb begin
    hit = 1'b0;
    idx = '0;
    i = '0;
    for (int k = 0; k < DEPTH; k++) begin
      i = head[AW-1:0] + AW'(k);
      if (PW'(k) < cnt && entries[i].valid && entries[i].addr == addr) begin
        hit = 1'b1;
        idx = i;
      end
    end
  end
endmodule

// File: rtl/store_write_buffer.sv
// store_write_buffer: in-order store FIFO with load forwarding, d-cache drain and fence handshake
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [ADDR_WIDTH-1:0]    i_push_addr,
  input  logic [DATA_WIDTH-1:0]    i_push_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  input  logic                     i_ld_valid,
  input  logic [ADDR_WIDTH-1:0]    i_ld_addr,
  output logic                     o_take_write_buffer,
  output logic                     o_fwd_valid,
  output logic [DATA_WIDTH-1:0]    o_fwd_data,
  output logic                     o_drain_valid,
  output logic [ADDR_WIDTH-1:0]    o_drain_addr,
  output logic [DATA_WIDTH-1:0]    o_drain_data,
  input  logic                     i_drain_ready,
  input  logic                     i_fence,
  output logic                     o_fence_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  wb_entry_t mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [AW-1:0] hit_idx;
  logic full, empty, push_ok, pop, hit;
  wb_fence_state_e state, state_next;
  assign full = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
  assign empty = head == tail;
  assign push_ok = i_push & ~full;
  assign pop = ~empty & i_drain_ready;
  assign o_full = full;
  assign o_empty = empty;
  assign o_count = tail - head;
  assign o_drain_valid = ~empty;
  assign o_drain_addr = mem[head[AW-1:0]].addr;
  assign o_drain_data = mem[head[AW-1:0]].data;
  assign o_take_write_buffer = i_ld_valid & hit;
  assign o_fwd_valid = o_take_write_buffer;
  assign o_fwd_data = o_take_write_buffer ? mem[hit_idx].data : '0;
  assign o_fence_done = state == WB_DONE;
  wb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_match (
    .entries(mem),
    .head(head),
    .tail(tail),
    .addr(i_ld_addr),
    .hit(hit),
    .idx(hit_idx)
  );
  always_comb begin
    state_next = state == WB_IDLE ? (i_fence ? (empty ? WB_DONE : WB_WAIT) : WB_IDLE) :
                 state == WB_WAIT ? (empty ? WB_DONE : WB_WAIT) :
                 (i_fence ? WB_DONE : WB_IDLE);
  end
  // push and pop never hit the same slot: that would need a full buffer, which rejects the push
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      state <= WB_IDLE;
      for (int j = 0; j < DEPTH; j++) mem[j].valid <= 1'b0;
    end else begin
      state <= state_next;
      if (push_ok) begin
        mem[tail[AW-1:0]] <= '{valid: 1'b1, addr: i_push_addr, data: i_push_data};
        tail <= tail + PW'(1);
      end
      if (pop) begin
        mem[head[AW-1:0]].valid <= 1'b0;
        head <= head + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed and random stimulus against a queue-based reference model
module tb_store_write_buffer;
  import store_write_buffer_pkg::*;
  localparam int D = WB_DEPTH;
  typedef struct {
    logic [WB_ADDR_WIDTH-1:0] a;
    logic [WB_DATA_WIDTH-1:0] d;
  } ent_t;
  logic clk = 1'b0;
  logic rst, i_push, i_ld_valid, i_drain_ready, i_fence;
  logic [WB_ADDR_WIDTH-1:0] i_push_addr, i_ld_addr, o_drain_addr;
  logic [WB_DATA_WIDTH-1:0] i_push_data, o_fwd_data, o_drain_data;
  logic o_full, o_empty, o_take_write_buffer, o_fwd_valid, o_drain_valid, o_fence_done;
  logic [$clog2(D):0] o_count;
  int checks = 0;
  int errors = 0;
  ent_t q[$];
  bit done_m = 0;
  always #5 clk = ~clk;
  store_write_buffer dut (
    .clk(clk), .rst(rst),
    .i_push(i_push), .i_push_addr(i_push_addr), .i_push_data(i_push_data),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .i_ld_valid(i_ld_valid), .i_ld_addr(i_ld_addr),
    .o_take_write_buffer(o_take_write_buffer), .o_fwd_valid(o_fwd_valid), .o_fwd_data(o_fwd_data),
    .o_drain_valid(o_drain_valid), .o_drain_addr(o_drain_addr), .o_drain_data(o_drain_data),
    .i_drain_ready(i_drain_ready), .i_fence(i_fence), .o_fence_done(o_fence_done)
  );
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(bit rs, bit p, logic [WB_ADDR_WIDTH-1:0] pa, logic [WB_DATA_WIDTH-1:0] pd,
                      bit rdy, bit lv, logic [WB_ADDR_WIDTH-1:0] la, bit f);
    bit hit_m = 0;
    logic [WB_DATA_WIDTH-1:0] fd_m = '0;
    int n;
    @(negedge clk);
    rst = rs; i_push = p; i_push_addr = pa; i_push_data = pd;
    i_drain_ready = rdy; i_ld_valid = lv; i_ld_addr = la; i_fence = f;
    #1;
    n = q.size();
    if (lv)
      for (int i = n - 1; i >= 0 && !hit_m; i--)
        if (q[i].a == la) begin hit_m = 1; fd_m = q[i].d; end
    check("count", 64'(o_count), 64'(n));
    check("full", 64'(o_full), 64'(n == D));
    check("empty", 64'(o_empty), 64'(n == 0));
    check("drain_valid", 64'(o_drain_valid), 64'(n != 0));
    if (n != 0) begin
      check("drain_addr", 64'(o_drain_addr), 64'(q[0].a));
      check("drain_data", 64'(o_drain_data), 64'(q[0].d));
    end
    check("take_wb", 64'(o_take_write_buffer), 64'(hit_m));
    check("fwd_valid", 64'(o_fwd_valid), 64'(hit_m));
    check("fwd_data", 64'(o_fwd_data), 64'(fd_m));
    check("fence_done", 64'(o_fence_done), 64'(done_m));
    @(posedge clk);
    if (rs) begin
      q.delete();
      done_m = 0;
    end else begin
      done_m = f && (done_m || n == 0);
      if (rdy && n > 0) void'(q.pop_front());
      if (p && n < D) q.push_back('{a: pa, d: pd});
    end
  endtask
  task automatic idle(bit rdy);
    step(0, 0, '0, '0, rdy, 0, '0, 0);
  endtask
  bit fence_req;
  initial begin
    rst = 1; i_push = 0; i_push_addr = '0; i_push_data = '0;
    i_drain_ready = 0; i_ld_valid = 0; i_ld_addr = '0; i_fence = 0;
    repeat (2) @(posedge clk);
    idle(0);
    step(0, 1, 30'h10, 32'h1111, 0, 0, '0, 0);
    idle(0);
    idle(1);
    idle(0);
    for (int i = 0; i < 5; i++) step(0, 1, 30'h40 + 30'(i), 32'hA000 + 32'(i), 0, 0, '0, 0);
    step(0, 0, '0, '0, 0, 1, 30'h44, 0);
    repeat (5) idle(1);
    step(0, 1, 30'h20, 32'hAAAA, 0, 0, '0, 0);
    step(0, 1, 30'h20, 32'hBBBB, 0, 1, 30'h20, 0);
    step(0, 0, '0, '0, 0, 1, 30'h20, 0);
    step(0, 0, '0, '0, 0, 1, 30'h24, 0);
    repeat (2) step(0, 0, '0, '0, 1, 1, 30'h20, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 30'h50 + 30'(i), 32'hB000 + 32'(i), 0, 0, '0, 0);
    step(0, 1, 30'h60, 32'hDEAD, 1, 0, '0, 0);
    idle(0);
    repeat (4) idle(1);
    step(0, 1, 30'h30, 32'h300, 0, 0, '0, 0);
    step(0, 1, 30'h31, 32'h301, 0, 0, '0, 0);
    for (int i = 0; i < 10; i++)
      step(0, 1, 30'h30 + 30'(i % 2), 32'h400 + 32'(i), 1, 1, 30'h30 + 30'(i % 3 == 0), 0);
    repeat (3) idle(1);
    step(0, 1, 30'h70, 32'h7070, 0, 0, '0, 0);
    step(0, 1, 30'h71, 32'h7171, 0, 0, '0, 0);
    repeat (2) step(0, 0, '0, '0, 0, 0, '0, 1);
    repeat (5) step(0, 0, '0, '0, 1, 0, '0, 1);
    repeat (2) idle(0);
    step(0, 0, '0, '0, 0, 0, '0, 1);
    step(0, 0, '0, '0, 0, 0, '0, 1);
    idle(0);
    idle(0);
    for (int i = 0; i < 3; i++) step(0, 1, 30'h80 + 30'(i), 32'h8000 + 32'(i), 0, 0, '0, 0);
    step(1, 1, 30'h90, 32'h9000, 1, 0, '0, 0);
    step(0, 0, '0, '0, 0, 1, 30'h80, 0);
    fence_req = 0;
    for (int i = 0; i < 400; i++) begin
      if (!fence_req && $urandom_range(0, 19) == 0) fence_req = 1;
      else if (fence_req && done_m && $urandom_range(0, 2) == 0) fence_req = 0;
      step(0, $urandom_range(0, 1) == 1, 30'($urandom_range(0, 5)), $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, 30'($urandom_range(0, 6)), fence_req);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
